// File: rtl/spi_byte_tx.sv
// spi_byte_tx: mode-0 SPI controller sending one MSB-first byte per valid/ready handshake.
// Optional receive capture of sdi is enabled by defining SPI_RX_CAPTURE_EN.
module spi_byte_tx #(
    parameter int unsigned DIV      = 4,
    parameter int unsigned CS_LEAD  = 2,
    parameter int unsigned CS_TRAIL = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       sck,
    output logic       sdo,
    output logic       cs
`ifdef SPI_RX_CAPTURE_EN
    ,
    input  logic       sdi,
    output logic [7:0] rx_data,
    output logic       rx_valid
`endif
);

    localparam int unsigned DW   = $clog2(DIV) + 1;
    localparam int unsigned PMAX = (CS_LEAD > CS_TRAIL) ? CS_LEAD : CS_TRAIL;
    localparam int unsigned PW   = $clog2(PMAX) + 1;

    localparam logic [DW-1:0] DIV_RELOAD   = DW'(DIV - 1);
    localparam logic [PW-1:0] LEAD_RELOAD  = PW'(CS_LEAD - 1);
    localparam logic [PW-1:0] TRAIL_RELOAD = PW'(CS_TRAIL - 1);
    localparam logic [3:0]    HP_LAST      = 4'd15;
    localparam logic [3:0]    HP_FALL8     = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [DW-1:0] div_q, div_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [3:0]    hp_q, hp_d;
    logic          sck_q, sck_d;
    logic          cs_q, cs_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
`ifdef SPI_RX_CAPTURE_EN
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
`endif

    // sdo is the shift register MSB; it is cleared whenever the frame ends
    assign sdo      = shreg_q[7];
    assign sck      = sck_q;
    assign cs       = cs_q;
    assign busy     = busy_q;
    assign tx_ready = ready_q;
`ifdef SPI_RX_CAPTURE_EN
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            div_q      <= '0;
            ph_q       <= '0;
            hp_q       <= '0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
`ifdef SPI_RX_CAPTURE_EN
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            div_q      <= div_d;
            ph_q       <= ph_d;
            hp_q       <= hp_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
`ifdef SPI_RX_CAPTURE_EN
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
`endif
        end
    end

    // hp_q counts completed sck half-periods; the 16th is the low phase after the last fall
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        div_d      = div_q;
        ph_d       = ph_q;
        hp_d       = hp_q;
        sck_d      = sck_q;
        cs_d       = cs_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
`ifdef SPI_RX_CAPTURE_EN
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (tx_valid && ready_q) begin
                    shreg_d = tx_data;
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    ph_d    = LEAD_RELOAD;
                    state_d = LEAD;
`ifdef SPI_RX_CAPTURE_EN
                    rx_sh_d = '0;
`endif
                end
            end

            LEAD: begin
                if (ph_q == '0) begin
                    sck_d   = 1'b1;
                    div_d   = DIV_RELOAD;
                    hp_d    = '0;
                    state_d = SHIFT;
`ifdef SPI_RX_CAPTURE_EN
                    rx_sh_d = {rx_sh_q[6:0], sdi};
`endif
                end else begin
                    ph_d = ph_q - PW'(1);
                end
            end

            SHIFT: begin
                if (div_q == '0) begin
                    div_d = DIV_RELOAD;
                    if (hp_q == HP_LAST) begin
                        ph_d    = TRAIL_RELOAD;
                        state_d = TRAIL;
                    end else begin
                        sck_d = ~sck_q;
                        hp_d  = hp_q + 4'd1;
                        // falls 1..7 advance the data; after fall 8 bit 0 is held
                        if (sck_q && (hp_q != HP_FALL8)) begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end
`ifdef SPI_RX_CAPTURE_EN
                        if (!sck_q) begin
                            rx_sh_d = {rx_sh_q[6:0], sdi};
                        end
`endif
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end

            TRAIL: begin
                if (ph_q == '0) begin
                    cs_d    = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    shreg_d = '0;
                    state_d = IDLE;
`ifdef SPI_RX_CAPTURE_EN
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
`endif
                end else begin
                    ph_d = ph_q - PW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_byte_tx.sv
// Directed bench for spi_byte_tx (DIV=2, CS_LEAD=2, CS_TRAIL=2) with a model SPI receiver.
// Define SPI_RX_CAPTURE_EN to also exercise the receive-capture option.
module tb_spi_byte_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       sck;
    logic       sdo;
    logic       cs;
`ifdef SPI_RX_CAPTURE_EN
    logic [7:0] rx_data;
    logic       rx_valid;
`endif

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    spi_byte_tx #(
        .DIV      (2),
        .CS_LEAD  (2),
        .CS_TRAIL (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .sck      (sck),
        .sdo      (sdo),
        .cs       (cs)
`ifdef SPI_RX_CAPTURE_EN
        ,
        .sdi      (sdo),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`endif
    );

    always #5 clk = ~clk;

    // Model receiver: shifts sdo on each sck rise while cs is high, sampled at negedge
    logic       sck_prev = 1'b0;
    logic       cs_prev  = 1'b0;
    int         frame_cnt = 0;
    int         cur_len = 0, cur_bits = 0, last_len = 0, last_bits = 0;
    int         gap_len = 0, last_gap = 0;
    logic [7:0] cur_byte = 8'h00, last_byte = 8'h00, prev_byte = 8'h00;
`ifdef SPI_RX_CAPTURE_EN
    int         rxv_cnt = 0;
    logic [7:0] rx_cap = 8'h00;
    logic       rxv_at_fall = 1'b0;
`endif

    always @(negedge clk) begin
        if (cs) begin
            if (!cs_prev) begin
                cur_len  = 1;
                cur_bits = 0;
                cur_byte = 8'h00;
                last_gap = gap_len;
            end else begin
                cur_len++;
            end
            if (sck && !sck_prev) begin
                cur_bits++;
                cur_byte = {cur_byte[6:0], sdo};
            end
        end else begin
            if (cs_prev) begin
                last_len  = cur_len;
                last_bits = cur_bits;
                prev_byte = last_byte;
                last_byte = cur_byte;
                frame_cnt++;
                gap_len   = 1;
`ifdef SPI_RX_CAPTURE_EN
                rxv_at_fall = rx_valid;
`endif
            end else begin
                gap_len++;
            end
        end
`ifdef SPI_RX_CAPTURE_EN
        if (rx_valid) begin
            rxv_cnt++;
            rx_cap = rx_data;
        end
`endif
        sck_prev = sck;
        cs_prev  = cs;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("frame_timeout", 32'(frame_cnt >= target), 32'd1);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    int base;

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        check("in_reset", {sck, cs, sdo, busy, tx_ready}, 5'b00001);
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle", {sck, cs, sdo, busy, tx_ready}, 5'b00001);
        end
`ifdef SPI_RX_CAPTURE_EN
        check("rx_reset", {rx_valid, rx_data}, 9'h000);
`endif

        // 2: single frame 0xA5
        base = frame_cnt;
        send(8'hA5);
        check("accept_outs", {cs, sdo, busy, tx_ready}, 4'b1110);
        wait_frames(base + 1, 200);
        check("a5_len", 32'(last_len), 32'd36);
        check("a5_bits", 32'(last_bits), 32'd8);
        check("a5_byte", last_byte, 8'hA5);
        check("a5_end", {sck, cs, sdo, busy, tx_ready}, 5'b00001);

        // 3: tx_valid held, back-to-back 0x3C then 0xC3
        tick();
        base     = frame_cnt;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_data  = 8'hC3;
        wait_frames(base + 1, 200);
        tick();
        tx_valid = 1'b0;
        check("b2b_second_cs", cs, 1'b1);
        wait_frames(base + 2, 200);
        check("b2b_first", prev_byte, 8'h3C);
        check("b2b_second", last_byte, 8'hC3);
        check("b2b_gap", 32'(last_gap), 32'd1);
        check("b2b_len", 32'(last_len), 32'd36);

        // 4: mid-frame changes ignored
        tick();
        base = frame_cnt;
        send(8'h12);
        repeat (10) tick();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("mid_busy", busy, 1'b1);
        wait_frames(base + 1, 200);
        check("mid_byte", last_byte, 8'h12);
        check("mid_bits", 32'(last_bits), 32'd8);
        repeat (20) tick();
        check("mid_no_extra", 32'(frame_cnt), 32'(base + 1));
        check("mid_idle", {cs, tx_ready}, 2'b01);

        // 5: reset after the 3rd sck rise, then 0x81
`ifdef SPI_RX_CAPTURE_EN
        rxv_cnt = 0;
`endif
        send(8'hF0);
        begin
            int n = 0;
            while (cur_bits < 3 && n < 100) begin
                tick();
                n++;
            end
        end
        check("abort_reached", {sck, 32'(cur_bits)}, {1'b1, 32'd3});
        reset = 1'b1;
        #1;
        check("abort_lines", {sck, cs, sdo, busy, tx_ready}, 5'b00001);
        tick();
        reset = 1'b0;
        tick();
`ifdef SPI_RX_CAPTURE_EN
        check("abort_no_rxv", 32'(rxv_cnt), 32'd0);
`endif
        base = frame_cnt;
        send(8'h81);
        wait_frames(base + 1, 200);
        check("post_abort_byte", last_byte, 8'h81);
        check("post_abort_bits", 32'(last_bits), 32'd8);
        check("post_abort_len", 32'(last_len), 32'd36);

`ifdef SPI_RX_CAPTURE_EN
        // 6: loopback capture of 0x5A
        tick();
        rxv_cnt = 0;
        base    = frame_cnt;
        send(8'h5A);
        wait_frames(base + 1, 200);
        repeat (3) tick();
        check("rx_pulses", 32'(rxv_cnt), 32'd1);
        check("rx_data", rx_cap, 8'h5A);
        check("rx_at_fall", rxv_at_fall, 1'b1);
        check("rx_tx_byte", last_byte, 8'h5A);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
